// File: rtl/credit_sender_mpi.sv
`default_nettype none
// ============================================================================
// Module   : credit_sender_mpi
// Purpose  : Transmit side of the MPI credit link. Buffers flits from a local
//            producer in a small FIFO and sends them one per cycle on a
//            valid/data link, as long as the remote receiver has returned
//            enough credits (yummies) to hold them.
// Ports    : clk_i      - clock, rising edge
//            rst_i      - synchronous active-high reset
//            valid_i    - producer flit valid
//            data_i     - producer flit
//            ready_o    - a flit can be accepted this cycle
//            yummy_i    - one credit returned by the remote receiver
//            valid_o    - data_o carries a flit sent this cycle
//            data_o     - outgoing flit
//            credit_o   - current credit count
//            fifo_cnt_o - current FIFO occupancy
//            err_o      - sticky credit-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module credit_sender_mpi #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            valid_i,
  input  logic [DATA_W-1:0]               data_i,
  output logic                            ready_o,
  input  logic                            yummy_i,
  output logic                            valid_o,
  output logic [DATA_W-1:0]               data_o,
  output logic [$clog2(CREDITS+1)-1:0]    credit_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt_o,
  output logic                            err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);

  localparam logic [CNT_W-1:0] C_FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0] C_MAX_CRED  = CRD_W'(CREDITS);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CRD_W-1:0]  r_credit;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_err;

  logic w_push;
  logic w_pop;

  // Both handshakes depend only on registered state, so there is no
  // combinational path from yummy_i or valid_i to either decision.
  assign ready_o = (r_cnt != C_FULL_CNT);
  assign w_push  = valid_i & ready_o;
  assign w_pop   = (r_cnt != '0) & (r_credit != '0);

  // Storage carries no reset: an entry is only ever read after being written.
  // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_credit <= C_MAX_CRED;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_data   <= r_mem[r_rd_ptr];
        r_valid  <= 1'b1;
      end else begin
        r_valid  <= 1'b0;
      end

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase

      // A yummy while already holding every credit means the remote side
      // returned more than it was sent; keep the count and flag it.
      if (w_pop && !yummy_i) begin
        r_credit <= r_credit - CRD_W'(1);
      end else if (!w_pop && yummy_i) begin
        if (r_credit == C_MAX_CRED) begin
          r_err <= 1'b1;
        end else begin
          r_credit <= r_credit + CRD_W'(1);
        end
      end
    end
  end

  assign valid_o    = r_valid;
  assign data_o     = r_data;
  assign credit_o   = r_credit;
  assign fifo_cnt_o = r_cnt;
  assign err_o      = r_err;

endmodule
`default_nettype wire

// File: doc/credit_sender_mpi.md
Name: credit_sender_mpi

Overview:
- Transmit-side counterpart of the MPI receiver stage: buffers 64-bit flits from a local producer and emits them on a valid/data link to the remote node.
- Credit-based flow control: each flit sent consumes one credit; each yummy returned by the remote receiver restores one.
- Sits directly upstream of the MPI send path. Its valid_o/data_o feed the DPI send call.
- Its yummy_i is driven from the DPI yummy-receive call.

Parameters:
- DATA_W, 64, flit width in bits.
- FIFO_DEPTH, 4, local buffer entries; power of two, at least 2.
- CREDITS, 3, initial and maximum credit count; equals the remote receiver buffer depth; at least 1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  producer flit valid.
- data_i  in  DATA_W  producer flit.
- ready_o  out  1  block can accept a flit this cycle.
- yummy_i  in  1  one credit returned by the remote receiver this cycle.
- valid_o  out  1  flit on data_o is sent this cycle.
- data_o  out  DATA_W  outgoing flit.
- credit_o  out  $clog2(CREDITS+1)  current credit count.
- fifo_cnt_o  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- err_o  out  1  sticky: credit overflow seen.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - Outputs: valid_o=0, data_o=0, credit_o=CREDITS, fifo_cnt_o=0, err_o=0.
  - FIFO pointers cleared; ready_o=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all buffered flits and any in-flight valid_o. Credits are restored to CREDITS regardless of prior count.
- Input handshake:
  - push = valid_i & ready_o.
  - ready_o = (fifo_cnt_o != FIFO_DEPTH), combinational from registered state only.
  - When full, no push is accepted, even if a pop occurs in the same cycle.
  - valid_i with ready_o=0 is ignored. The producer must hold the flit.
- Send decision (each cycle): pop = (fifo_cnt_o != 0) & (credit_o != 0).
  - On pop, at the edge: valid_o<=1, data_o<=FIFO head, read pointer advances.
  - Otherwise valid_o<=0 and data_o holds its last value.
  - valid_o is a one-cycle pulse per flit; back-to-back pulses allowed.
- Latency:
  - A flit accepted at edge N is popped at edge N+1 when credit is available.
  - valid_o is therefore high in the cycle after edge N+1: minimum 2 cycles from accept to output.
  - No bypass path.
- Ordering: strict FIFO; flits leave in acceptance order.
- Credit counter (next value):
  - pop & !yummy_i: credit-1.
  - !pop & yummy_i: credit+1, saturating at CREDITS.
  - pop & yummy_i: unchanged.
  - Neither: unchanged.
  - A yummy arriving while credit_o=0 enables pop only from the next cycle; pop uses the registered credit.
- Overflow: yummy_i=1 & !pop & credit_o==CREDITS leaves credit unchanged and sets err_o=1. err_o stays set until reset.
- Occupancy: fifo_cnt_o next = cnt + push - pop. Simultaneous push and pop leave it unchanged. Pointers wrap modulo FIFO_DEPTH.
- Empty with credits available: valid_o=0, credits unchanged.
- Invariant (checked by assertion): credit_o + flits in flight at the remote receiver = CREDITS.

Test Plan:
- Reset then a single push of 0xDEADBEEF_00000001 at edge 1 -> valid_o=1 with that data in the cycle after edge 2; credit_o 3->2; fifo_cnt_o returns to 0.
- Push 5 flits 0x1..0x5 back-to-back, CREDITS=3, no yummy:
  - valid_o pulses exactly 3 times (data 0x1,0x2,0x3); credit_o=0.
  - fifo_cnt_o settles at 2.
  - ready_o stays 1 (depth 4 is never reached with only 2 flits held).
- Continue the previous scenario: yummy_i pulse for 1 cycle -> credit_o=1 next cycle; 0x4 sent one cycle later; credit_o=0.
  - A second yummy sends 0x5.
  - Order checked: 0x1..0x5.
- Credits 0 and FIFO full (4 flits held):
  - ready_o=0; valid_i with 0xAA is not accepted; fifo_cnt_o stays 4.
  - Yummy -> one pop; ready_o=1 the cycle after.
- Idle with credit_o=3, yummy_i=1 -> err_o=1 next cycle, credit_o stays 3.
  - Simultaneous pop and yummy at credit 2 -> credit stays 2, err_o unchanged.
- Assert rst_i while 3 flits are queued and credit_o=0 -> next cycle valid_o=0, fifo_cnt_o=0, credit_o=3, err_o=0; no queued flit ever appears on data_o.
